// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin sequencer in front of one shared combinational ALU.
// Optional build macro ALU_OP_CHECK_EN: illegal opcodes are answered with an error response.
module alu_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [1:0]            i_req_valid,
    output logic [1:0]            o_req_ready,
    input  logic [2*DATA_W-1:0]   i_req_a,
    input  logic [2*DATA_W-1:0]   i_req_b,
    input  logic [2*OP_W-1:0]     i_req_op,
    output logic [1:0]            o_rsp_valid,
    input  logic [1:0]            i_rsp_ready,
    output logic [DATA_W-1:0]     o_rsp_result,
    output logic                  o_rsp_zero,
    output logic                  o_rsp_err,
    output logic [DATA_W-1:0]     o_alu_a,
    output logic [DATA_W-1:0]     o_alu_b,
    output logic [OP_W-1:0]       o_alu_ctrl,
    input  logic [DATA_W-1:0]     i_alu_result,
    input  logic                  i_alu_zero,
    output logic                  o_busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state;
    logic                owner;
    logic                last_grant;
    logic [1:0]          grant;
    logic                gnt_idx;
    logic                accept_req;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [OP_W-1:0]     sel_op;

`ifdef ALU_OP_CHECK_EN
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_W'(4'b0000), OP_W'(4'b0001), OP_W'(4'b0010), OP_W'(4'b0011),
            OP_W'(4'b0100), OP_W'(4'b0110), OP_W'(4'b0111), OP_W'(4'b1000),
            OP_W'(4'b1001), OP_W'(4'b1010), OP_W'(4'b1011), OP_W'(4'b1100):
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction
`endif

    // Grant is only offered in IDLE; on contention the requester that was not served last wins.
    always_comb begin
        grant = '0;
        if (state == IDLE) begin
            case (i_req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

    always_comb begin
        gnt_idx    = grant[1];
        accept_req = |grant;
        sel_a      = gnt_idx ? i_req_a[2*DATA_W-1:DATA_W] : i_req_a[DATA_W-1:0];
        sel_b      = gnt_idx ? i_req_b[2*DATA_W-1:DATA_W] : i_req_b[DATA_W-1:0];
        sel_op     = gnt_idx ? i_req_op[2*OP_W-1:OP_W]    : i_req_op[OP_W-1:0];
    end

    assign o_req_ready = grant;
    assign o_busy      = (state != IDLE);

`ifndef ALU_OP_CHECK_EN
    assign o_rsp_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            o_rsp_valid  <= '0;
            o_rsp_result <= '0;
            o_rsp_zero   <= 1'b0;
            o_alu_a      <= '0;
            o_alu_b      <= '0;
            o_alu_ctrl   <= OP_W'(4'b0010);
`ifdef ALU_OP_CHECK_EN
            o_rsp_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept_req) begin
                        owner <= gnt_idx;
`ifdef ALU_OP_CHECK_EN
                        // Illegal op bypasses the ALU entirely, so its operand registers keep their value.
                        if (!op_legal(sel_op)) begin
                            o_rsp_result <= '0;
                            o_rsp_zero   <= 1'b1;
                            o_rsp_err    <= 1'b1;
                            o_rsp_valid  <= grant;
                            state        <= RESP;
                        end else
`endif
                        begin
                            o_alu_a    <= sel_a;
                            o_alu_b    <= sel_b;
                            o_alu_ctrl <= sel_op;
                            state      <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    o_rsp_result <= i_alu_result;
                    o_rsp_zero   <= i_alu_zero;
`ifdef ALU_OP_CHECK_EN
                    o_rsp_err    <= 1'b0;
`endif
                    o_rsp_valid  <= owner ? 2'b10 : 2'b01;
                    state        <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready[owner]) begin
                        o_rsp_valid <= '0;
                        last_grant  <= owner;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single ops plus arbitration, hold and reset sequences.
module tb_alu_arbiter;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic [1:0]   i_req_valid;
    logic [1:0]   o_req_ready;
    logic [63:0]  i_req_a;
    logic [63:0]  i_req_b;
    logic [7:0]   i_req_op;
    logic [1:0]   o_rsp_valid;
    logic [1:0]   i_rsp_ready;
    logic [31:0]  o_rsp_result;
    logic         o_rsp_zero;
    logic         o_rsp_err;
    logic [31:0]  o_alu_a;
    logic [31:0]  o_alu_b;
    logic [3:0]   o_alu_ctrl;
    logic [31:0]  i_alu_result;
    logic         i_alu_zero;
    logic         o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_op(i_req_op),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_result(o_rsp_result), .o_rsp_zero(o_rsp_zero), .o_rsp_err(o_rsp_err),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_ctrl(o_alu_ctrl),
        .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Stand-in for the shared ALU; shifts take the amount from operand A.
    always_comb begin
        case (o_alu_ctrl)
            4'b0000: i_alu_result = o_alu_a & o_alu_b;
            4'b0001: i_alu_result = o_alu_a | o_alu_b;
            4'b0010: i_alu_result = o_alu_a + o_alu_b;
            4'b0110: i_alu_result = o_alu_a - o_alu_b;
            4'b0111: i_alu_result = {31'd0, $signed(o_alu_a) < $signed(o_alu_b)};
            4'b1000: i_alu_result = o_alu_b << o_alu_a[4:0];
            4'b1001: i_alu_result = o_alu_b >> o_alu_a[4:0];
            4'b1010: i_alu_result = $unsigned($signed(o_alu_b) >>> o_alu_a[4:0]);
            default: i_alu_result = o_alu_a ^ o_alu_b;
        endcase
        i_alu_zero = (i_alu_result == 32'd0);
    end

    typedef struct {
        logic        req;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic        zero;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(logic req, logic [31:0] a, logic [31:0] b, logic [3:0] op,
                                logic [31:0] res, logic zero, logic err, int lat);
        vec_t v;
        v.req = req; v.a = a; v.b = b; v.op = op;
        v.res = res; v.zero = zero; v.err = err; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input logic r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        if (r) begin
            i_req_a[63:32] = a; i_req_b[63:32] = b; i_req_op[7:4] = op;
        end else begin
            i_req_a[31:0] = a;  i_req_b[31:0] = b;  i_req_op[3:0] = op;
        end
        i_req_valid[r] = 1'b1;
    endtask

    // Called at the negedge of the handshake cycle; returns at the negedge where a response shows.
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(posedge i_clk); #1;
            lat++;
            @(negedge i_clk);
        end while (o_rsp_valid == 2'b00 && lat < 8);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_req_valid = '0;
        i_rsp_ready = '0;
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
    endtask

    task automatic run_op(input vec_t v);
        logic [31:0] pa, pb;
        logic [3:0]  pc;
        logic [1:0]  oh;
        int lat;
        pa = o_alu_a; pb = o_alu_b; pc = o_alu_ctrl;
        oh = v.req ? 2'b10 : 2'b01;
        drive_req(v.req, v.a, v.b, v.op);
        @(negedge i_clk);
        chk("req_ready", 32'(o_req_ready), 32'(oh));
        wait_rsp(lat);
        i_req_valid = '0;
        chk("latency", 32'(lat), 32'(v.lat));
        chk("rsp_valid", 32'(o_rsp_valid), 32'(oh));
        chk("rsp_result", o_rsp_result, v.res);
        chk("rsp_zero", 32'(o_rsp_zero), 32'(v.zero));
        chk("rsp_err", 32'(o_rsp_err), 32'(v.err));
        chk("busy_resp", 32'(o_busy), 32'd1);
        if (v.err) begin
            chk("alu_a_held", o_alu_a, pa);
            chk("alu_b_held", o_alu_b, pb);
            chk("alu_ctrl_held", 32'(o_alu_ctrl), 32'(pc));
        end else begin
            chk("alu_a", o_alu_a, v.a);
            chk("alu_b", o_alu_b, v.b);
            chk("alu_ctrl", 32'(o_alu_ctrl), 32'(v.op));
        end
        i_rsp_ready[v.req] = 1'b1;
        @(posedge i_clk); #1;
        i_rsp_ready = '0;
        @(negedge i_clk);
        chk("busy_idle", 32'(o_busy), 32'd0);
        chk("rsp_valid_clr", 32'(o_rsp_valid), 32'd0);
        @(posedge i_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ngrant, nrsp, cyc;
        vecs[0] = mk(1'b0, 32'd5,        32'd7,          4'b0010, 32'd12,         1'b0, 1'b0, 2);
        vecs[1] = mk(1'b0, 32'd9,        32'd4,          4'b0110, 32'd5,          1'b0, 1'b0, 2);
        vecs[2] = mk(1'b1, 32'd3,        32'd3,          4'b0110, 32'd0,          1'b1, 1'b0, 2);
        vecs[3] = mk(1'b1, 32'd4,        32'd1,          4'b1000, 32'd16,         1'b0, 1'b0, 2);
        vecs[4] = mk(1'b0, 32'd2,        32'hFFFF_FFF0,  4'b1010, 32'hFFFF_FFFC,  1'b0, 1'b0, 2);
        vecs[5] = mk(1'b0, 32'h0000_F0F0, 32'h0000_FF00, 4'b0000, 32'h0000_F000,  1'b0, 1'b0, 2);
        vecs[6] = mk(1'b1, 32'h0000_F0F0, 32'h0000_0F0F, 4'b0001, 32'h0000_FFFF,  1'b0, 1'b0, 2);
        vecs[7] = mk(1'b0, 32'd4,        32'h8000_0000,  4'b1001, 32'h0800_0000,  1'b0, 1'b0, 2);
        vecs[8] = mk(1'b1, 32'd3,        32'd5,          4'b0111, 32'd1,          1'b0, 1'b0, 2);
        vecs[9] = mk(1'b0, 32'hFFFF_FFFF, 32'd1,         4'b0010, 32'd0,          1'b1, 1'b0, 2);
`ifdef ALU_OP_CHECK_EN
        vecs[10] = mk(1'b0, 32'd6,       32'd3,          4'b0101, 32'd0,          1'b1, 1'b1, 1);
`else
        vecs[10] = mk(1'b0, 32'd6,       32'd3,          4'b0101, 32'd5,          1'b0, 1'b0, 2);
`endif

        i_req_a = '0; i_req_b = '0; i_req_op = '0;
        do_reset();
        @(negedge i_clk);
        chk("rst_req_ready", 32'(o_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_result", o_rsp_result, 32'd0);
        chk("rst_zero", 32'(o_rsp_zero), 32'd0);
        chk("rst_err", 32'(o_rsp_err), 32'd0);
        chk("rst_alu_a", o_alu_a, 32'd0);
        chk("rst_alu_b", o_alu_b, 32'd0);
        chk("rst_alu_ctrl", 32'(o_alu_ctrl), 32'h2);
        chk("rst_busy", 32'(o_busy), 32'd0);
        @(posedge i_clk); #1;

        for (int i = 0; i < 11; i++) run_op(vecs[i]);

        // Both requesters continuously valid: grants alternate starting with requester 0.
        do_reset();
        drive_req(1'b0, 32'd9, 32'd4, 4'b0110);
        drive_req(1'b1, 32'd3, 32'd3, 4'b0110);
        i_rsp_ready = 2'b11;
        ngrant = 0; nrsp = 0; cyc = 0;
        while ((ngrant < 6 || nrsp < 6) && cyc < 60) begin
            @(negedge i_clk);
            if (o_req_ready != 2'b00) begin
                chk("rr_grant", 32'(o_req_ready), (ngrant % 2) ? 32'd2 : 32'd1);
                ngrant++;
            end
            if (o_rsp_valid != 2'b00) begin
                chk("rr_rsp_valid", 32'(o_rsp_valid), (nrsp % 2) ? 32'd2 : 32'd1);
                chk("rr_result", o_rsp_result, (nrsp % 2) ? 32'd0 : 32'd5);
                chk("rr_zero", 32'(o_rsp_zero), (nrsp % 2) ? 32'd1 : 32'd0);
                nrsp++;
            end
            @(posedge i_clk); #1;
            cyc++;
            if (ngrant >= 6) i_req_valid = '0;
        end
        chk("rr_grant_count", 32'(ngrant), 32'd6);
        chk("rr_rsp_count", 32'(nrsp), 32'd6);
        i_req_valid = '0;
        i_rsp_ready = '0;
        @(posedge i_clk); #1;

        // Owner 1 holds off its response; non-owner ready is ignored and requester 0 is not served.
        drive_req(1'b1, 32'd4, 32'd1, 4'b1000);
        @(negedge i_clk);
        chk("hold_req_ready", 32'(o_req_ready), 32'd2);
        wait_rsp(lat);
        i_req_valid = '0;
        chk("hold_latency", 32'(lat), 32'd2);
        drive_req(1'b0, 32'd5, 32'd7, 4'b0010);
        i_rsp_ready = 2'b01;
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #1;
            @(negedge i_clk);
            chk("hold_rsp_valid", 32'(o_rsp_valid), 32'd2);
            chk("hold_result", o_rsp_result, 32'd16);
            chk("hold_no_ready", 32'(o_req_ready), 32'd0);
        end
        i_rsp_ready = 2'b11;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("after_hold_grant0", 32'(o_req_ready), 32'd1);
        wait_rsp(lat);
        i_req_valid = '0;
        chk("after_hold_rsp_valid", 32'(o_rsp_valid), 32'd1);
        chk("after_hold_result", o_rsp_result, 32'd12);
        @(posedge i_clk); #1;
        i_rsp_ready = '0;
        @(posedge i_clk); #1;

        // Asynchronous reset while in EXEC discards the op and restores the priority pointer.
        drive_req(1'b1, 32'd1, 32'd2, 4'b0110);
        @(negedge i_clk);
        chk("mid_req_ready", 32'(o_req_ready), 32'd2);
        @(posedge i_clk); #1;
        i_req_valid = '0;
        chk("mid_busy_exec", 32'(o_busy), 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("mid_rst_alu_ctrl", 32'(o_alu_ctrl), 32'h2);
        chk("mid_rst_alu_a", o_alu_a, 32'd0);
        #2 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        drive_req(1'b0, 32'd8, 32'd3, 4'b0110);
        drive_req(1'b1, 32'd7, 32'd7, 4'b0110);
        @(negedge i_clk);
        chk("post_rst_grant0", 32'(o_req_ready), 32'd1);
        wait_rsp(lat);
        i_req_valid = '0;
        chk("post_rst_latency", 32'(lat), 32'd2);
        chk("post_rst_rsp_valid", 32'(o_rsp_valid), 32'd1);
        chk("post_rst_result", o_rsp_result, 32'd5);
        i_rsp_ready = 2'b01;
        @(posedge i_clk); #1;
        i_rsp_ready = '0;
        @(negedge i_clk);
        chk("post_rst_idle", 32'(o_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
